// File: rtl/if_stage_if.sv
// Fetch-stage bundle: ROM request/response, decode-side presentation and redirects.
// Handshakes: a ROM request is taken when if_rom_req_o & rom_gnt_i at a rising edge;
// an instruction is consumed when if_valid_o & id_ready_i at a rising edge.
// if_valid_o never waits on id_ready_i.
interface if_stage_if;
  logic        if_rom_req_o;
  logic [31:0] if_rom_addr_o;
  logic        rom_gnt_i;
  logic        rom_rvalid_i;
  logic [31:0] rom_inst_i;

  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  logic        ex_ins_flush_i;
  logic [31:0] ex_redirect_pc_i;
  logic        id_jump_i;
  logic [31:0] id_jump_pc_i;

  modport master (
    output if_rom_req_o, if_rom_addr_o, if_valid_o, if_pc_o, if_inst_o,
    input  rom_gnt_i, rom_rvalid_i, rom_inst_i, id_ready_i,
           ex_ins_flush_i, ex_redirect_pc_i, id_jump_i, id_jump_pc_i
  );

  modport slave (
    input  if_rom_req_o, if_rom_addr_o, if_valid_o, if_pc_o, if_inst_o,
    output rom_gnt_i, rom_rvalid_i, rom_inst_i, id_ready_i,
           ex_ins_flush_i, ex_redirect_pc_i, id_jump_i, id_jump_pc_i
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC, credit-limited ROM requests, response queue, redirect/drop.
// Define IF_BYPASS_EN to let a response reach the outputs in its arrival cycle.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IQ_DEPTH = 2
) (
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);
  localparam int PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam int CW = PW + 1;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_CNT = cnt_t'(IQ_DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  cnt_t          outstanding;
  cnt_t          drop_cnt;
  cnt_t          count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   q_pc   [IQ_DEPTH];
  logic [31:0]   q_inst [IQ_DEPTH];

  logic        redirect;
  logic [31:0] target;
  logic [CW:0] in_use;
  logic        credit_ok;
  logic        req;
  logic        grant;
  logic        rsp_drop;
  logic        rsp_keep;
  logic        bypass_hit;
  logic        bypass_take;
  logic        push;
  logic        pop;

  assign redirect = bus.ex_ins_flush_i | bus.id_jump_i;
  assign target   = bus.ex_ins_flush_i ? bus.ex_redirect_pc_i : bus.id_jump_pc_i;

  // Credits cover both queued and in-flight entries, so a push always has room.
  assign in_use    = {1'b0, outstanding} + {1'b0, count};
  assign credit_ok = in_use < {1'b0, DEPTH_CNT};
  assign req       = rst_n & ~redirect & credit_ok;
  assign grant     = req & bus.rom_gnt_i;

  assign rsp_drop = bus.rom_rvalid_i & (drop_cnt != '0);
  assign rsp_keep = bus.rom_rvalid_i & (drop_cnt == '0) & ~redirect;

`ifdef IF_BYPASS_EN
  assign bypass_hit  = rsp_keep & (count == '0);
  assign bypass_take = bypass_hit & bus.id_ready_i;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = rsp_keep & ~bypass_take;
  assign pop  = (count != '0) & bus.id_ready_i & ~redirect;

  assign bus.if_rom_req_o  = req;
  assign bus.if_rom_addr_o = fetch_pc;

  always_comb begin
    bus.if_valid_o = 1'b0;
    bus.if_pc_o    = 32'h0;
    bus.if_inst_o  = 32'h0;
    if (count != '0) begin
      bus.if_valid_o = 1'b1;
      bus.if_pc_o    = q_pc[rd_ptr];
      bus.if_inst_o  = q_inst[rd_ptr];
    end else if (bypass_hit) begin
      bus.if_valid_o = 1'b1;
      bus.if_pc_o    = rsp_pc;
      bus.if_inst_o  = bus.rom_inst_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(grant) - cnt_t'(bus.rom_rvalid_i);
      if (redirect) begin
        // Every response still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        rsp_pc   <= target;
        drop_cnt <= outstanding - cnt_t'(bus.rom_rvalid_i);
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (grant)    fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
        if (rsp_drop) drop_cnt <= drop_cnt - cnt_t'(1);
        if (push)     wr_ptr   <= wr_ptr + PW'(1);
        if (pop)      rd_ptr   <= rd_ptr + PW'(1);
        count <= count + cnt_t'(push) - cnt_t'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= rsp_pc;
      q_inst[wr_ptr] <= bus.rom_inst_i;
    end
  end

  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst_n)
    drop_cnt <= outstanding);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == DEPTH_CNT)));
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: ROM model with configurable latency, PC/instruction scoreboard.
module tb_if_stage;
  localparam int          IQ_DEPTH = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IF_BYPASS_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  if_stage_if bus ();
  if_stage #(.RESET_PC(RESET_PC), .IQ_DEPTH(IQ_DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    bit          flush;
    bit          jump;
    logic [31:0] ex_pc;
    logic [31:0] jp_pc;
    logic [31:0] exp_req0;
    logic [31:0] exp_req1;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] rom_addr_q[$];
  int          rom_due_q[$];
  int          last_due = 0;
  logic [31:0] exp_fetch;
  logic [31:0] exp_out;
  int          n_pops = 0;
  bit          prev_redir = 0;

  int lat_mode = 0, lat_fix = 1, ready_mode = 0;
  bit gnt_rand = 0, gnt_off = 0, rand_redir = 0;
  bit pend_flush = 0, pend_jump = 0, auto_flush2 = 0, fired2 = 0;
  logic [31:0] pend_ex, pend_jp, auto_tgt;

  bit seen_req = 0, seen_req2 = 0, seen_pop = 0;
  logic [31:0] first_req_addr, second_req_addr, first_pop_pc;
  int first_gnt_cyc = -1, first_valid_cyc = -1;
  logic last_req, last_valid;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    int          n_out;
    int          lat;
    int          due;
    int          r;
    logic [31:0] tmp;
    logic        redir;
    logic [31:0] tgt;
    cyc++;
    n_out = rom_addr_q.size();
    if (n_out > 0 && rom_due_q[0] <= cyc) begin
      bus.rom_rvalid_i = 1'b1;
      bus.rom_inst_i   = rom_fn(rom_addr_q[0]);
      void'(rom_addr_q.pop_front());
      void'(rom_due_q.pop_front());
    end else begin
      bus.rom_rvalid_i = 1'b0;
      bus.rom_inst_i   = $urandom();
    end
    bus.rom_gnt_i  = gnt_off ? 1'b0 : (gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    bus.id_ready_i = (ready_mode == 0) ? 1'b1 :
                     (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    bus.ex_ins_flush_i   = 1'b0;
    bus.id_jump_i        = 1'b0;
    bus.ex_redirect_pc_i = $urandom();
    bus.id_jump_pc_i     = $urandom();
    if (pend_flush || pend_jump) begin
      bus.ex_ins_flush_i   = pend_flush;
      bus.id_jump_i        = pend_jump;
      bus.ex_redirect_pc_i = pend_ex;
      bus.id_jump_pc_i     = pend_jp;
      pend_flush = 0;
      pend_jump  = 0;
    end else if (auto_flush2 && n_out >= 2 && bus.rom_rvalid_i) begin
      bus.ex_ins_flush_i   = 1'b1;
      bus.ex_redirect_pc_i = auto_tgt;
      auto_flush2 = 0;
      fired2      = 1;
    end else if (rand_redir && $urandom_range(0, 39) == 0) begin
      r = int'($urandom_range(1, 3));
      bus.ex_ins_flush_i   = r[0];
      bus.id_jump_i        = r[1];
      tmp = $urandom();
      bus.ex_redirect_pc_i = tmp & 32'hFFFF_FFFC;
      tmp = $urandom();
      bus.id_jump_pc_i     = tmp & 32'hFFFF_FFFC;
    end

    @(negedge clk);
    redir = bus.ex_ins_flush_i | bus.id_jump_i;
    // Redirect priority taken straight from the rule: EX wins over ID.
    tgt = bus.ex_ins_flush_i ? bus.ex_redirect_pc_i : bus.id_jump_pc_i;
    last_req   = bus.if_rom_req_o;
    last_valid = bus.if_valid_o;
    if (redir)      check("req_masked", 32'(bus.if_rom_req_o), 32'd0);
    if (prev_redir) check("valid_after_redirect", 32'(bus.if_valid_o), 32'd0);
    if (!bus.if_valid_o) check("inst_zero_idle", bus.if_inst_o, 32'h0);
    if (bus.if_rom_req_o && bus.rom_gnt_i) begin
      check("fetch_addr", bus.if_rom_addr_o, exp_fetch);
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      if (!seen_req) begin
        first_req_addr = bus.if_rom_addr_o;
        seen_req = 1;
      end else if (!seen_req2) begin
        second_req_addr = bus.if_rom_addr_o;
        seen_req2 = 1;
      end
      lat = (lat_mode != 0) ? int'($urandom_range(1, 4)) : lat_fix;
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rom_addr_q.push_back(bus.if_rom_addr_o);
      rom_due_q.push_back(due);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (bus.if_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (bus.if_valid_o && bus.id_ready_i && !redir) begin
      check("out_pc", bus.if_pc_o, exp_out);
      check("out_inst", bus.if_inst_o, rom_fn(exp_out));
      if (!seen_pop) begin
        first_pop_pc = bus.if_pc_o;
        seen_pop = 1;
      end
      exp_out = exp_out + 32'd4;
      n_pops++;
    end
    if (redir) begin
      exp_fetch = tgt;
      exp_out   = tgt;
      seen_req  = 0;
      seen_req2 = 0;
      seen_pop  = 0;
    end
    prev_redir = redir;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rom_gnt_i        = 1'b0;
    bus.rom_rvalid_i     = 1'b0;
    bus.rom_inst_i       = 32'h0;
    bus.id_ready_i       = 1'b0;
    bus.ex_ins_flush_i   = 1'b0;
    bus.ex_redirect_pc_i = 32'h0;
    bus.id_jump_i        = 1'b0;
    bus.id_jump_pc_i     = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   32'(bus.if_rom_req_o), 32'd0);
    check({tag, "_addr"},  bus.if_rom_addr_o, RESET_PC);
    check({tag, "_valid"}, 32'(bus.if_valid_o), 32'd0);
    check({tag, "_pc"},    bus.if_pc_o, 32'h0);
    check({tag, "_inst"},  bus.if_inst_o, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    int   p0;
    tbl[0] = '{1'b1, 1'b1, 32'h0000_0200, 32'h0000_0300, 32'h0000_0200, 32'h0000_0204};
    tbl[1] = '{1'b0, 1'b1, 32'h0000_0040, 32'h0000_0300, 32'h0000_0300, 32'h0000_0304};
    tbl[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0500, 32'h0000_0100, 32'h0000_0104};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0080, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[4] = '{1'b0, 1'b1, 32'h0000_0010, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC};

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    check("first_req", 32'(bus.if_rom_req_o), 32'd1);
    check("first_req_addr", bus.if_rom_addr_o, RESET_PC);
    exp_fetch = RESET_PC;
    exp_out   = RESET_PC;

    // Streaming with a 1-cycle ROM and decode always ready.
    repeat (20) step();
    check("grant_to_valid", 32'(first_valid_cyc - first_gnt_cyc), 32'(EXP_LAT));
    check("first_out_pc", first_pop_pc, RESET_PC);

    // Decode stalls: queue fills to depth and requests stop.
    ready_mode = 1;
    repeat (10) step();
    check("stall_req_low", 32'(last_req), 32'd0);
    check("stall_valid", 32'(last_valid), 32'd1);
    gnt_off = 1;
    ready_mode = 0;
    p0 = n_pops;
    for (int k = 0; k < 20; k++) begin
      step();
      if (!last_valid) break;
    end
    check("stall_drain_count", 32'(n_pops - p0), 32'(IQ_DEPTH));
    gnt_off = 0;

    // EX flush with two responses in flight, one returning in the flush cycle.
    lat_fix = 3;
    auto_tgt = 32'h0000_0100;
    auto_flush2 = 1;
    fired2 = 0;
    for (int k = 0; k < 60 && !fired2; k++) step();
    check("flush2_fired", 32'(fired2), 32'd1);
    for (int k = 0; k < 40 && !seen_pop; k++) step();
    check("flush2_next_pc", first_pop_pc, 32'h0000_0100);
    auto_flush2 = 0;

    // Redirect vectors: priority and PC wrap.
    lat_fix = 1;
    for (int i = 0; i < 5; i++) begin
      repeat (3) step();
      pend_flush = tbl[i].flush;
      pend_jump  = tbl[i].jump;
      pend_ex    = tbl[i].ex_pc;
      pend_jp    = tbl[i].jp_pc;
      step();
      for (int k = 0; k < 20 && !seen_req2; k++) step();
      for (int k = 0; k < 20 && !seen_pop; k++) step();
      check($sformatf("tbl%0d_req0", i), first_req_addr, tbl[i].exp_req0);
      check($sformatf("tbl%0d_req1", i), second_req_addr, tbl[i].exp_req1);
      check($sformatf("tbl%0d_out0", i), first_pop_pc, tbl[i].exp_req0);
    end

    // Random latency, grants, decode readiness and redirects.
    lat_mode = 1;
    gnt_rand = 1;
    ready_mode = 2;
    rand_redir = 1;
    p0 = n_pops;
    for (int k = 0; k < 20000 && (n_pops - p0) < 1000; k++) step();
    check("random_1000_done", 32'((n_pops - p0) >= 1000), 32'd1);

    // Asynchronous reset in mid-operation.
    idle_inputs();
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    rom_addr_q.delete();
    rom_due_q.delete();
    last_due = 0;
    prev_redir = 0;
    exp_fetch = RESET_PC;
    exp_out = RESET_PC;
    seen_pop = 0;
    lat_mode = 0;
    lat_fix = 1;
    gnt_rand = 0;
    ready_mode = 0;
    rand_redir = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_req", 32'(bus.if_rom_req_o), 32'd1);
    repeat (10) step();
    check("post_reset_first_pc", first_pop_pc, RESET_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
